// File: rtl/program_sequencer_if.sv
// rtl/program_sequencer_if.sv - load/control/issue bundle between a program_sequencer and its driver
interface program_sequencer_if #(
   parameter int AW = 4
);
   logic          LoadEn;
   logic [AW-1:0] LoadAddr;
   logic [11:0]   LoadData;
   logic          Start;
   logic          Stop;
   logic [AW-1:0] LastAddr;
   logic [11:0]   InstrOut;
   logic          Valid;
   logic [AW-1:0] PC;
   logic          Busy;
   logic          Done;

   modport master (
      output LoadEn, LoadAddr, LoadData, Start, Stop, LastAddr,
      input  InstrOut, Valid, PC, Busy, Done
   );

   modport slave (
      input  LoadEn, LoadAddr, LoadData, Start, Stop, LastAddr,
      output InstrOut, Valid, PC, Busy, Done
   );
endinterface

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - loadable program store issuing 12-bit words to the TinyCPU In bus
// Define LOOP_EN to wrap PC at LastAddr and run until Stop instead of halting in DONE.
module program_sequencer #(
   parameter int          AW       = 4,
   parameter logic [11:0] NOP_WORD = 12'h000
) (
   input logic               Clk,
   input logic               Clr,
   program_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [AW-1:0] pc_q;
   logic [AW-1:0] last_q;
   logic [11:0]   instr_q;
   logic          valid_q;

   logic [11:0]   mem_q [2**AW];
   logic [11:0]   rd_word_d;

   // Program memory is deliberately outside the reset domain so Clr keeps the program.
   always_ff @(posedge Clk) begin
      if (bus.LoadEn && (state_q != RUN)) begin
         mem_q[bus.LoadAddr] <= bus.LoadData;
      end
   end

   assign rd_word_d = mem_q[pc_q];

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         state_q <= IDLE;
         pc_q    <= '0;
         last_q  <= '0;
         instr_q <= NOP_WORD;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               instr_q <= NOP_WORD;
               valid_q <= 1'b0;
               if (bus.Start && !bus.Stop) begin
                  state_q <= RUN;
                  pc_q    <= '0;
                  last_q  <= bus.LastAddr;
               end
            end
            RUN: begin
               if (bus.Stop) begin
                  state_q <= IDLE;
                  instr_q <= NOP_WORD;
                  valid_q <= 1'b0;
               end else begin
                  instr_q <= rd_word_d;
                  valid_q <= 1'b1;
                  if (pc_q == last_q) begin
`ifdef LOOP_EN
                     pc_q <= '0;
`else
                     state_q <= DONE;
`endif
                  end else begin
                     pc_q <= pc_q + AW'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               instr_q <= NOP_WORD;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.InstrOut = instr_q;
   assign bus.Valid    = valid_q;
   assign bus.PC       = pc_q;
   assign bus.Busy     = (state_q == RUN);
   assign bus.Done     = (state_q == DONE);
endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - scoreboard bench for program_sequencer
module tb_program_sequencer;
   localparam int AW = 4;
   localparam int DEPTH = 2**AW;
   localparam logic [11:0] NOP = 12'h000;

   logic clk = 1'b0;
   logic clr = 1'b1;

   program_sequencer_if #(.AW(AW)) bus ();

   program_sequencer #(.AW(AW), .NOP_WORD(NOP)) dut (
      .Clk (clk),
      .Clr (clr),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [11:0] mem_m [DEPTH];
   logic [11:0] exp_q [$];

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every issued word must be the next one the model predicted.
   always @(negedge clk) begin
      if (!clr) begin
         if (bus.Valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_issue", 32'(bus.InstrOut), 32'hFFFF_FFFF);
            end else begin
               check("issued_word", 32'(bus.InstrOut), 32'(exp_q.pop_front()));
            end
         end else begin
            check("idle_nop", 32'(bus.InstrOut), 32'(NOP));
         end
      end
   end

   task automatic load(input int addr, input int data, input bit accepted);
      bus.LoadEn   = 1'b1;
      bus.LoadAddr = AW'(addr);
      bus.LoadData = 12'(data);
      tick();
      bus.LoadEn = 1'b0;
      if (accepted) mem_m[addr] = 12'(data);
   endtask

   task automatic run(input int last, input int stop_after, input bit blk_wr);
      int nw;
      nw = (stop_after < 0) ? last + 1 : stop_after;
      for (int i = 0; i < nw; i++) exp_q.push_back(mem_m[i]);
      bus.LastAddr = AW'(last);
      bus.Start    = 1'b1;
      bus.Stop     = 1'b0;
      tick();
      bus.Start    = 1'b0;
      bus.LastAddr = AW'($urandom_range(0, DEPTH - 1));
      if (blk_wr) begin
         bus.LoadEn   = 1'b1;
         bus.LoadAddr = AW'(1);
         bus.LoadData = 12'hBBB;
         tick();
         bus.LoadEn = 1'b0;
         for (int i = 1; i < nw; i++) tick();
      end else begin
         for (int i = 0; i < nw; i++) tick();
      end
      if (stop_after < 0) begin
         check("done_at_last", 32'(bus.Done), 1);
         check("busy_at_last", 32'(bus.Busy), 0);
         check("pc_at_last", 32'(bus.PC), 32'(last));
         tick();
         check("done_hold", 32'(bus.Done), 1);
         check("queue_drained", exp_q.size(), 0);
      end else begin
         bus.Stop  = 1'b1;
         bus.Start = 1'($urandom_range(0, 1));
         tick();
         bus.Stop  = 1'b0;
         bus.Start = 1'b0;
         check("stop_busy", 32'(bus.Busy), 0);
         check("stop_done", 32'(bus.Done), 0);
         check("stop_pc", 32'(bus.PC), 32'(stop_after));
         check("stop_drained", exp_q.size(), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.LoadEn = 1'b0; bus.LoadAddr = '0; bus.LoadData = '0;
      bus.Start = 1'b0; bus.Stop = 1'b0; bus.LastAddr = '0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 12'h000;
      #12;
      check("rst_instr", 32'(bus.InstrOut), 32'(NOP));
      check("rst_valid", 32'(bus.Valid), 0);
      check("rst_busy", 32'(bus.Busy), 0);
      check("rst_done", 32'(bus.Done), 0);
      check("rst_pc", 32'(bus.PC), 0);
      @(posedge clk); #1;
      clr = 1'b0;
      for (int i = 0; i < DEPTH; i++) load(i, 0, 1);

`ifdef LOOP_EN
      load(0, 12'h101, 1); load(1, 12'h202, 1); load(2, 12'h303, 1);
      for (int i = 0; i < 7; i++) exp_q.push_back(mem_m[i % 3]);
      bus.LastAddr = AW'(2);
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         check("loop_no_done", 32'(bus.Done), 0);
         check("loop_busy", 32'(bus.Busy), 1);
      end
      bus.Stop = 1'b1;
      tick();
      bus.Stop = 1'b0;
      check("loop_stop_busy", 32'(bus.Busy), 0);
      check("loop_stop_pc", 32'(bus.PC), 32'(7 % 3));
      tick();
      check("loop_drained", exp_q.size(), 0);
`else
      // Basic run, then a blocked write during RUN, then an accepted write in DONE.
      load(0, 12'h1A5, 1); load(1, 12'h2C3, 1); load(2, 12'h400, 1); load(3, 12'h7FF, 1);
      run(3, -1, 0);
      run(3, -1, 1);
      load(1, 12'hBBB, 1);
      run(3, -1, 0);

      // Stop after two words with Start colliding; collision in IDLE starts nothing.
      run(5, 2, 0);
      bus.Start = 1'b1; bus.Stop = 1'b1;
      tick();
      bus.Start = 1'b0; bus.Stop = 1'b0;
      tick(); tick();
      check("collision_idle_busy", 32'(bus.Busy), 0);
      check("collision_idle_queue", exp_q.size(), 0);

      // Boundaries: single word and full memory without wrap.
      for (int i = 0; i < DEPTH; i++) load(i, $urandom_range(0, 4095), 1);
      run(0, -1, 0);
      run(DEPTH - 1, -1, 0);

      // Asynchronous clear while address 2 is on the bus.
      for (int i = 0; i < 8; i++) exp_q.push_back(mem_m[i]);
      bus.LastAddr = AW'(7);
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      tick(); tick(); tick();
      check("pre_clr_word2", 32'(bus.InstrOut), 32'(mem_m[2]));
      #1 clr = 1'b1;
      #1;
      check("clr_instr", 32'(bus.InstrOut), 32'(NOP));
      check("clr_valid", 32'(bus.Valid), 0);
      check("clr_busy", 32'(bus.Busy), 0);
      check("clr_pc", 32'(bus.PC), 0);
      check("clr_words_before", exp_q.size(), 6);
      exp_q.delete();
      tick();
      clr = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("post_clr_idle", 32'(bus.Busy), 0);

      // Randomized program updates and runs.
      for (int it = 0; it < 10; it++) begin
         int last;
         int stp;
         int n;
         n = $urandom_range(1, 4);
         for (int j = 0; j < n; j++) load($urandom_range(0, DEPTH - 1), $urandom_range(0, 4095), 1);
         last = $urandom_range(0, DEPTH - 1);
         stp = -1;
         if (last > 0 && $urandom_range(0, 1) == 1) stp = $urandom_range(1, last);
         run(last, stp, 0);
      end
`endif
      tick(); tick();
      check("final_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Upstream feeder for the TinyCPU datapath. Holds a small loadable program of 12-bit instruction words, {opcode[11:8], data[7:0]}.
- On command, issues the words one per clock on InstrOut, which connects directly to the CPU's 12-bit In bus.
- Provides a run/stop/done control FSM and a program counter so benches and top-level boards can execute a program without hand-driving In each cycle.

Parameters:
- AW, 4: address width; program depth = 2**AW words.
- NOP_WORD, 12'h000: word driven on InstrOut whenever no instruction is being issued. Must decode to "no register enabled" in the CPU.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Clr  input  1  asynchronous, active-high reset.
- LoadEn  input  1  write LoadData into program memory at LoadAddr.
- LoadAddr  input  AW  program memory write address.
- LoadData  input  12  instruction word to store.
- Start  input  1  begin execution at address 0.
- Stop  input  1  abort execution.
- LastAddr  input  AW  address of the final instruction; sampled when Start is accepted.
- InstrOut  output  12  instruction word to the CPU In bus.
- Valid  output  1  InstrOut carries a program word this cycle.
- PC  output  AW  address of the next word to be issued.
- Busy  output  1  high while in RUN.
- Done  output  1  high while in DONE.

Behaviour:
- Reset (Clr high, asynchronous):
  - State IDLE, PC=0, InstrOut=NOP_WORD, Valid=0, Busy=0, Done=0, latched LastAddr register=0.
  - Program memory is not cleared.
- Reset takes effect immediately, including mid-RUN. After Clr deasserts, the block stays in IDLE until a new Start.
- States: IDLE, RUN, DONE. Busy = (state==RUN). Done = (state==DONE).
- Memory write:
  - On a rising edge with LoadEn=1 and state!=RUN, mem[LoadAddr] <= LoadData.
  - LoadEn is ignored in RUN.
  - No read-during-write forwarding is needed because writes are blocked in RUN.
- IDLE/DONE + Start=1 + Stop=0:
  - next state RUN, PC<=0, LastAddr latched.
  - InstrOut stays NOP_WORD and Valid=0 in that cycle.
- RUN, each edge with Stop=0:
  - InstrOut <= mem[PC], Valid <= 1.
  - If PC==latched LastAddr: state <= DONE and PC holds. Otherwise PC <= PC+1.
- Latency: the word at address k appears on InstrOut k+1 cycles after the edge that sampled Start, then stays for one cycle. Words at 0..LastAddr are issued back to back with no gaps.
- Leaving RUN to DONE: the last word is issued on the transition edge. On the following edge InstrOut <= NOP_WORD and Valid <= 0. Done stays high until Start or Clr.
- Stop=1 in RUN: next edge state <= IDLE, InstrOut <= NOP_WORD, Valid <= 0, PC holds its current value.
- Start and Stop in the same cycle: Stop wins. In IDLE/DONE nothing happens; in RUN it aborts.
- Start while already in RUN is ignored.
- LastAddr = 2**AW-1 runs the full memory. PC does not wrap in the base configuration.
- LastAddr = 0 issues exactly one word.
- LastAddr changes after Start have no effect until the next Start.

Optional Feature:
- Macro LOOP_EN.
- Defined: reaching PC==LastAddr in RUN does not enter DONE. PC wraps to 0 and issue continues without a bubble, so the word after mem[LastAddr] is mem[0]. Only Stop or Clr ends execution, and Done is never asserted.
- Undefined: behaviour as above; the program halts in DONE.

Test Plan:
- Reset mid-RUN: Clr pulsed asynchronously between edges while issuing address 2 -> InstrOut=12'h000, Valid=0, Busy=0, PC=0 immediately. Nothing is issued until a new Start.
- Basic run: load mem[0..3]=12'h1A5,12'h2C3,12'h400,12'h7FF; LastAddr=3; pulse Start -> InstrOut shows those four words on cycles 1-4 with Valid=1, then NOP_WORD with Valid=0. Done=1 from cycle 4 onward; PC=3.
- Stop abort plus collision: during RUN assert Start and Stop together after 2 words -> state IDLE next edge, InstrOut=NOP_WORD, exactly 2 words issued. The same pair asserted in IDLE produces no run.
- Load blocked in RUN: LoadEn with LoadAddr=1, LoadData=12'hBBB during RUN -> mem[1] unchanged on the next run. The same write in DONE takes effect.
- Boundary: LastAddr=0 -> one word, then DONE. LastAddr=15 (AW=4) -> 16 words, then DONE, PC=15, no wrap.
- LOOP_EN build: LastAddr=2, mem[0..2]=12'h101,12'h202,12'h303 -> repeating sequence 101,202,303,101,... with Done=0. Stop after 7 words -> IDLE.
